// File: rtl/ppm_pkg.sv
// Shared types for the PPM symbol demodulator: FSM state encoding and slot-index sizing.
package ppm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    SEARCH,
    OUTPUT
  } ppm_state_e;

  // Bits needed to index one slot of a PPM frame.
  function automatic int slot_width(input int order);
    return (order > 1) ? $clog2(order) : 1;
  endfunction

endpackage

// File: rtl/ppm_acc_bank.sv
// Bank of PPM_ORDER saturating slot accumulators with one add port, one read port and a clear-all.
module ppm_acc_bank
  import ppm_pkg::*;
#(
  parameter int PPM_ORDER = 8,
  parameter int CHIP_BITS = 3,
  parameter int ACC_BITS  = 6
) (
  input  logic                            clk,
  input  logic                            rstb,
  input  logic                            clear,
  input  logic                            add_en,
  input  logic [slot_width(PPM_ORDER)-1:0] add_idx,
  input  logic [CHIP_BITS-1:0]            add_val,
  input  logic [slot_width(PPM_ORDER)-1:0] rd_idx,
  output logic [ACC_BITS-1:0]             rd_val
);

  localparam int SUM_W = ACC_BITS + 1;
  localparam logic [ACC_BITS-1:0] ACC_MAX = '1;

  logic [ACC_BITS-1:0] acc_q [PPM_ORDER];
  logic [SUM_W-1:0]    sum;

  // One spare bit catches the carry so the slot pins at full scale instead of wrapping.
  always_comb begin
    sum = {1'b0, acc_q[add_idx]} + SUM_W'(add_val);
  end

  // NOTE: the accumulators are reset explicitly because a reset must discard any partial symbol.
  always_ff @(posedge clk) begin
    if (!rstb || clear) begin
      for (int i = 0; i < PPM_ORDER; i++) acc_q[i] <= '0;
    end else if (add_en) begin
      acc_q[add_idx] <= sum[ACC_BITS] ? ACC_MAX : sum[ACC_BITS-1:0];
    end
  end

  assign rd_val = acc_q[rd_idx];

endmodule

// File: rtl/ppm_symbol_demod.sv
// PPM symbol demodulator: accumulates SPAD chip counts per slot over N frames, then picks the peak slot.
module ppm_symbol_demod
  import ppm_pkg::*;
#(
  parameter int PPM_ORDER  = 8,
  parameter int CHIP_BITS  = 3,
  parameter int ACC_BITS   = 6,
  parameter int FRAME_BITS = 4
) (
  input  logic                             clk,
  input  logic                             rstb,
  input  logic [CHIP_BITS-1:0]             chip_in,
  input  logic                             chip_valid,
  output logic                             chip_ready,
  input  logic [FRAME_BITS-1:0]            frames_per_symbol,
  input  logic [ACC_BITS-1:0]              corr_threshold,
  output logic [slot_width(PPM_ORDER)-1:0] sym_out,
  output logic [ACC_BITS-1:0]              peak_value,
  output logic                             threshold_unmet,
  output logic                             sym_valid,
  input  logic                             sym_ready,
  output logic                             busy
);

  localparam int IDX_W = slot_width(PPM_ORDER);
  localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(PPM_ORDER - 1);

  ppm_state_e state_q, state_d;

  logic [IDX_W-1:0]      slot_q;
  logic [FRAME_BITS-1:0] frame_q, frames_lat_q, frames_eff;
  logic [ACC_BITS-1:0]   max_q, peak_q, rd_val, cand_max;
  logic [IDX_W-1:0]      idx_q, sym_q, cand_idx;
  logic                  unmet_q;
  logic                  chip_accept, slot_wrap, last_chip, scan_last, out_done;

  assign chip_accept = chip_valid && chip_ready;
  assign slot_wrap   = (slot_q == LAST_SLOT);
  assign last_chip   = chip_accept && (state_q == ACCUM) && slot_wrap
                       && (frame_q == frames_lat_q - FRAME_BITS'(1));
  assign scan_last   = (state_q == SEARCH) && slot_wrap;
  assign out_done    = sym_valid && sym_ready;
  assign frames_eff  = (frames_per_symbol == '0) ? FRAME_BITS'(1) : frames_per_symbol;

  // Strictly-greater update keeps the lowest index on ties.
  assign cand_max = (rd_val > max_q) ? rd_val : max_q;
  assign cand_idx = (rd_val > max_q) ? slot_q : idx_q;

  ppm_acc_bank #(
    .PPM_ORDER(PPM_ORDER),
    .CHIP_BITS(CHIP_BITS),
    .ACC_BITS (ACC_BITS)
  ) u_acc_bank (
    .clk    (clk),
    .rstb   (rstb),
    .clear  (out_done),
    .add_en (chip_accept),
    .add_idx(slot_q),
    .add_val(chip_in),
    .rd_idx (slot_q),
    .rd_val (rd_val)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstb) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: next-state and output logic assign defaults first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (chip_accept) state_d = ACCUM;
      ACCUM:   if (last_chip)   state_d = SEARCH;
      SEARCH:  if (scan_last)   state_d = OUTPUT;
      OUTPUT:  if (sym_ready)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    chip_ready      = (state_q == IDLE) || (state_q == ACCUM);
    busy            = (state_q != IDLE);
    sym_valid       = (state_q == OUTPUT);
    sym_out         = '0;
    peak_value      = '0;
    threshold_unmet = 1'b0;
    if (sym_valid) begin
      sym_out         = sym_q;
      peak_value      = peak_q;
      threshold_unmet = unmet_q;
    end
  end

  // The slot counter doubles as the scan index: it is back at 0 when the last chip lands.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      slot_q       <= '0;
      frame_q      <= '0;
      frames_lat_q <= '0;
      max_q        <= '0;
      idx_q        <= '0;
      peak_q       <= '0;
      sym_q        <= '0;
      unmet_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (chip_accept) begin
            slot_q <= slot_q + IDX_W'(1);
            if (state_q == IDLE) frames_lat_q <= frames_eff;
            if (slot_wrap) frame_q <= last_chip ? '0 : frame_q + FRAME_BITS'(1);
          end
        end
        SEARCH: begin
          slot_q <= slot_q + IDX_W'(1);
          max_q  <= cand_max;
          idx_q  <= cand_idx;
          if (scan_last) begin
            peak_q  <= cand_max;
            sym_q   <= cand_idx;
            unmet_q <= (cand_max < corr_threshold);
          end
        end
        OUTPUT: begin
          if (sym_ready) begin
            slot_q  <= '0;
            frame_q <= '0;
            max_q   <= '0;
            idx_q   <= '0;
            peak_q  <= '0;
            sym_q   <= '0;
            unmet_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ppm_symbol_demod.sv
// Self-checking bench for ppm_symbol_demod: per-cycle comparison against a frame-level model plus literal checks.
module tb_ppm_symbol_demod;

  logic       clk = 1'b0;
  logic       rstb;
  logic [2:0] chip_in;
  logic       chip_valid;
  logic       chip_ready;
  logic [3:0] frames_per_symbol;
  logic [5:0] corr_threshold;
  logic [2:0] sym_out;
  logic [5:0] peak_value;
  logic       threshold_unmet;
  logic       sym_valid;
  logic       sym_ready;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  ppm_symbol_demod #(
    .PPM_ORDER (8),
    .CHIP_BITS (3),
    .ACC_BITS  (6),
    .FRAME_BITS(4)
  ) dut (
    .clk              (clk),
    .rstb             (rstb),
    .chip_in          (chip_in),
    .chip_valid       (chip_valid),
    .chip_ready       (chip_ready),
    .frames_per_symbol(frames_per_symbol),
    .corr_threshold   (corr_threshold),
    .sym_out          (sym_out),
    .peak_value       (peak_value),
    .threshold_unmet  (threshold_unmet),
    .sym_valid        (sym_valid),
    .sym_ready        (sym_ready),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: per-symbol slot sums, a fixed result delay, then a held result.
  int m_acc[8];
  int m_chips  = 0;
  int m_frames = 1;
  int m_wait   = 0;
  bit m_out    = 1'b0;
  int m_sym    = 0;
  int m_peak   = 0;
  bit m_unmet  = 1'b0;

  always @(posedge clk) begin
    if (!rstb) begin
      foreach (m_acc[i]) m_acc[i] = 0;
      m_chips = 0; m_wait = 0; m_out = 1'b0;
    end else if (m_out) begin
      if (sym_ready) begin
        foreach (m_acc[i]) m_acc[i] = 0;
        m_chips = 0; m_out = 1'b0;
      end
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        m_peak = 0; m_sym = 0;
        for (int i = 0; i < 8; i++) if (m_acc[i] > m_peak) begin m_peak = m_acc[i]; m_sym = i; end
        m_unmet = (m_peak < int'(corr_threshold));
        m_out   = 1'b1;
      end
    end else if (chip_valid) begin
      if (m_chips == 0) m_frames = (frames_per_symbol == 0) ? 1 : int'(frames_per_symbol);
      m_acc[m_chips % 8] = (m_acc[m_chips % 8] + int'(chip_in) > 63) ? 63 : m_acc[m_chips % 8] + int'(chip_in);
      m_chips++;
      if (m_chips == 8 * m_frames) m_wait = 8;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("chip_ready", chip_ready, (!m_out && m_wait == 0));
      check("busy", busy, (m_chips > 0 || m_wait > 0 || m_out));
      check("sym_valid", sym_valid, m_out);
      check("sym_out", sym_out, m_out ? m_sym : 0);
      check("peak_value", peak_value, m_out ? m_peak : 0);
      check("threshold_unmet", threshold_unmet, m_out ? m_unmet : 1'b0);
    end
  end

  int pat_a[8]    = '{1, 2, 3, 6, 0, 0, 0, 0};
  int pat_s5[8]   = '{0, 0, 0, 0, 0, 7, 0, 0};
  int pat_s2[8]   = '{0, 0, 7, 0, 0, 0, 0, 0};
  int pat_tie[8]  = '{0, 0, 4, 0, 0, 0, 4, 0};
  int pat_s1[8]   = '{0, 1, 0, 0, 0, 0, 0, 0};
  int pat_last[8] = '{0, 0, 0, 0, 0, 0, 0, 5};

  task automatic send_symbol(input int frames, input int ch[8], input int thr);
    int nf;
    nf = (frames == 0) ? 1 : frames;
    frames_per_symbol = 4'(frames);
    corr_threshold    = 6'(thr);
    for (int f = 0; f < nf; f++) begin
      for (int s = 0; s < 8; s++) begin
        chip_valid = 1'b1;
        chip_in    = 3'(ch[s]);
        @(posedge clk);
        @(negedge clk);
      end
    end
    chip_valid = 1'b0;
  endtask

  // Counts edges from the accepting edge of the last chip until sym_valid is seen.
  task automatic wait_result(output int lat);
    lat = 1;
    while (!sym_valid && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic handshake();
    sym_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sym_ready = 1'b0;
  endtask

  task automatic run_case(input string tag, input int frames, input int ch[8], input int thr,
                          input int exp_sym, input int exp_peak, input int exp_unmet);
    int lat;
    send_symbol(frames, ch, thr);
    wait_result(lat);
    check({tag, "_latency"}, lat, 9);
    check({tag, "_sym"}, sym_out, exp_sym);
    check({tag, "_peak"}, peak_value, exp_peak);
    check({tag, "_unmet"}, threshold_unmet, exp_unmet);
  endtask

  initial begin
    int lat;
    rstb = 1'b0; chip_in = '0; chip_valid = 1'b0; sym_ready = 1'b0;
    frames_per_symbol = 4'd1; corr_threshold = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp_en = 1'b1;
    check("rst_chip_ready", chip_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_sym_valid", sym_valid, 0);
    rstb = 1'b1;

    run_case("basic_thr2", 1, pat_a, 2, 3, 6, 0);
    handshake();
    run_case("basic_thr7", 1, pat_a, 7, 3, 6, 1);
    handshake();
    run_case("four_frames", 4, pat_s5, 28, 5, 28, 0);
    handshake();
    run_case("saturate", 15, pat_s2, 63, 2, 63, 0);
    handshake();

    // Result held while the consumer stalls and chips keep arriving.
    run_case("tie", 1, pat_tie, 0, 2, 4, 0);
    chip_valid = 1'b1; chip_in = 3'd7;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_sym", sym_out, 2);
      check("hold_peak", peak_value, 4);
      check("hold_ready", chip_ready, 0);
    end
    chip_valid = 1'b0;
    handshake();
    check("post_hs_busy", busy, 0);
    check("post_hs_ready", chip_ready, 1);
    run_case("cleared_frames0", 0, pat_s1, 2, 1, 1, 1);
    handshake();

    // Reset after three accepted chips discards the partial symbol.
    frames_per_symbol = 4'd1;
    for (int i = 0; i < 3; i++) begin
      chip_valid = 1'b1; chip_in = 3'd5;
      @(posedge clk);
      @(negedge clk);
    end
    chip_valid = 1'b0; rstb = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_valid", sym_valid, 0);
    check("midrst_peak", peak_value, 0);
    rstb = 1'b1;
    run_case("after_reset", 1, pat_last, 1, 7, 5, 0);

    // Reset while a result is pending drops it.
    rstb = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("outrst_valid", sym_valid, 0);
    check("outrst_sym", sym_out, 0);
    rstb = 1'b1;
    send_symbol(1, pat_a, 2);
    wait_result(lat);
    check("final_latency", lat, 9);
    check("final_sym", sym_out, 3);
    handshake();

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ppm_symbol_demod.md
PPM_SYMBOL_DEMOD -- requirements
Module: ppm_symbol_demod

Interface
REQ-001 SHALL have parameter PPM_ORDER, default 8: chips per PPM frame; power of 2, at least 2.
REQ-002 SHALL have parameter CHIP_BITS, default 3: width of one chip's SPAD count.
REQ-003 SHALL have parameter ACC_BITS, default 6: per-slot accumulator width; ACC_BITS >= CHIP_BITS.
REQ-004 SHALL have parameter FRAME_BITS, default 4: width of the frame-count configuration.
REQ-005 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rstb, input, 1: reset, synchronous and active-low.
REQ-007 SHALL have ports: chip_in in CHIP_BITS (count for current slot); chip_valid in 1; chip_ready out 1.
REQ-008 SHALL have ports: frames_per_symbol in FRAME_BITS (frames accumulated per symbol, 0 treated as 1); corr_threshold in ACC_BITS.
REQ-009 SHALL have ports: sym_out out log2(PPM_ORDER); peak_value out ACC_BITS; threshold_unmet out 1; sym_valid out 1; sym_ready in 1; busy out 1.

Function
REQ-010 SHALL implement FSM states IDLE, ACCUM, SEARCH, OUTPUT; chip_ready=1 only in IDLE/ACCUM; busy=1 in every state except IDLE.
REQ-011 SHALL accept a chip when chip_valid&&chip_ready; the first accepted chip in IDLE latches frames_per_symbol and moves to ACCUM.
REQ-012 SHALL add each accepted chip to accumulator[slot]; slot starts at 0, +1 per accepted chip, wraps PPM_ORDER-1 -> 0 and increments frame count on wrap.
REQ-013 SHALL saturate each accumulator at 2^ACC_BITS-1; never wrap.
REQ-014 SHALL move to SEARCH on the cycle after the last chip (slot PPM_ORDER-1) of the last latched frame is accepted.
REQ-015 SHALL scan accumulators 0..PPM_ORDER-1 one per cycle in SEARCH, updating the running max only on strictly greater, so ties resolve to lowest index.
REQ-016 SHALL enter OUTPUT after PPM_ORDER SEARCH cycles: sym_valid asserted exactly PPM_ORDER+1 cycles after the last chip handshake.
REQ-017 SHALL drive threshold_unmet = (peak_value < corr_threshold), corr_threshold sampled on SEARCH->OUTPUT transition.
REQ-018 SHALL hold sym_out, peak_value, threshold_unmet and sym_valid stable in OUTPUT until sym_valid&&sym_ready.
REQ-019 SHALL, on output handshake, clear all accumulators, slot and frame counters and return to IDLE next cycle; chip acceptance resumes that cycle.
REQ-020 SHALL ignore chip_in/chip_valid during SEARCH and OUTPUT (no accumulation, no counter change).
REQ-021 SHALL drive sym_out, peak_value, threshold_unmet to 0 whenever sym_valid=0.

Reset
REQ-022 SHALL, when rstb=0 at a clock edge, force IDLE, clear all accumulators and counters, and drive sym_valid=0, busy=0, chip_ready=1 (with rstb high), sym_out=0, peak_value=0, threshold_unmet=0.
REQ-023 SHALL discard any partial accumulation or pending output when reset occurs mid-ACCUM, mid-SEARCH or in OUTPUT; no symbol emitted.
REQ-024 SHALL take rstb priority over every handshake in the same cycle.

Structure
REQ-025 SHALL place the FSM state enum and the slot-index width function (log2 of PPM_ORDER) in shared package ppm_pkg.
REQ-026 SHALL instantiate one sub-module ppm_acc_bank: PPM_ORDER saturating accumulators with add-at-index, read-at-index and clear-all ports.

Verification (PPM_ORDER=8, CHIP_BITS=3, ACC_BITS=6, FRAME_BITS=4)
REQ-027 SHALL cover: frames=1, chips slot0..7 = 1,2,3,6,0,0,0,0, threshold 2 -> sym_out=3, peak_value=6, threshold_unmet=0, sym_valid 9 cycles after last chip.
REQ-028 SHALL cover: same chips, threshold 7 -> sym_out=3, peak_value=6, threshold_unmet=1.
REQ-029 SHALL cover: frames=4, slot5=7 every frame, others 0 -> sym_out=5, peak_value=28; frames=15, slot2=7 -> peak_value=63 (saturated), sym_out=2.
REQ-030 SHALL cover: tie, slots 2 and 6 = 4, others 0 -> sym_out=2, peak_value=4.
REQ-031 SHALL cover: sym_ready held low 10 cycles in OUTPUT with chip_valid=1 -> outputs stable, chip_ready=0, no accumulation; handshake -> IDLE next cycle, accumulators 0.
REQ-032 SHALL cover: rstb=0 after 3 accepted chips -> all outputs 0, IDLE; next full frame 0,0,0,0,0,0,0,5 -> sym_out=7, peak_value=5.
